i2s_tx: RTL and testbench

Master-mode I2S/left-justified audio transmitter with an internal sample FIFO. It generates SCK and WS from the system clock and serializes FIFO samples onto SDO MSB-first, one sample per enabled channel slot. It is the transmit counterpart of `EF_I2S` and shares its framing: 32 SCK per slot, 64 per frame, and the same prescaler and WS polarity, so `i2s_tx` can loop back into `EF_I2S` directly. The host side writes samples through a push port; the audio side is the three-wire serial bus.

---
 rtl/i2s_tx.sv | 186 ++++++++++++++++++
 tb/tb_i2s_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// i2s_tx: master-mode I2S / left-justified audio transmitter with a sample FIFO.
// Generates SCK and WS from clk: 32 SCK per slot, 64 SCK per frame.
// Samples are sent MSB-first on sdo, one sample per enabled channel slot.
// Optional build macro I2S_TX_MONO_DUP_EN: in mono modes (channels 10/01) the
// sample of the enabled slot is also sent in the disabled slot of the same
// frame, with one FIFO pop per frame.
module i2s_tx #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [7:0]    sck_prescaler,
  input  logic          left_justified,
  input  logic [5:0]    sample_size,
  input  logic [1:0]    channels,
  input  logic          fifo_wr,
  input  logic [DW-1:0] fifo_wdata,
  input  logic          fifo_clr,
  input  logic [AW:0]   fifo_level_threshold,
  input  logic          underrun_clr,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [AW:0]   fifo_level,
  output logic          fifo_level_below,
  output logic          underrun,
  output logic          sck,
  output logic          ws,
  output logic          sdo
);

  localparam int DEPTH = 1 << AW;

  // Left-align a right-aligned sample; bits below the sample come out zero.
  function automatic logic [31:0] align_sample(input logic [31:0] w, input logic [5:0] sz);
    logic [5:0] sh;
    if (sz == 6'd0 || sz > 6'd32) sh = 6'd0;
    else                          sh = 6'd32 - sz;
    return w << sh;
  endfunction

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level, level_nxt;
  logic          full_r, empty_r;
  logic          wr_ok, pop, pop_ok;
  logic [31:0]   head;

  logic [7:0]    cnt;
  logic          sck_r, ws_r;
  logic [4:0]    bitcnt;
  logic [31:0]   shreg_p0;
  logic          sdo_dly_p1;
  logic          tick, fall, boundary;
  logic          slot_en;
  logic [31:0]   load_val;
  logic          urun_set;
  logic          urun_r;

`ifdef I2S_TX_MONO_DUP_EN
  logic [31:0]   hold;
`endif

  // Full and empty are the registered cycle-start flags, so a write while full is
  // dropped even if a pop happens the same cycle, and a pop on empty is refused.
  assign wr_ok     = fifo_wr & ~full_r;
  assign pop_ok    = pop & ~empty_r;
  assign level_nxt = level + (AW+1)'(wr_ok) - (AW+1)'(pop_ok);
  assign head      = mem[rptr][31:0];

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_ok && !fifo_clr) mem[wptr] <= fifo_wdata;
  end

  // FIFO pointers, level and registered flags; clear overrides write and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else if (fifo_clr) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (wr_ok)  wptr <= wptr + AW'(1);
      if (pop_ok) rptr <= rptr + AW'(1);
      level   <= level_nxt;
      full_r  <= (level_nxt == (AW+1)'(DEPTH));
      empty_r <= (level_nxt == '0);
    end
  end

  assign tick     = en && (cnt == 8'd0);
  assign fall     = tick && sck_r;
  assign boundary = fall && (bitcnt == 5'd0);
  // ws is still 1 at the boundary that opens a left slot.
  assign slot_en  = ws_r ? channels[1] : channels[0];
  assign pop      = boundary && slot_en;

  // Choose what the next slot loads and whether an empty FIFO means underrun.
  always_comb begin
    load_val = '0;
    urun_set = 1'b0;
    if (slot_en) begin
      if (!empty_r) load_val = align_sample(head, sample_size);
      else          urun_set = boundary;
    end
`ifdef I2S_TX_MONO_DUP_EN
    // Disabled right slot repeats the left sample; a disabled left slot peeks
    // the head word that the following right slot will pop.
    else if (channels == 2'b10) begin
      load_val = hold;
    end else if (channels == 2'b01 && !empty_r) begin
      load_val = align_sample(head, sample_size);
    end
`endif
  end

`ifdef I2S_TX_MONO_DUP_EN
  // Remember the enabled-slot sample for the disabled slot that follows it.
  always_ff @(posedge clk) begin
    if (boundary && slot_en) hold <= load_val;
  end
`endif

  // Prescaler, SCK/WS generation, bit counter and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sck_r      <= 1'b0;
      ws_r       <= 1'b1;
      bitcnt     <= '0;
      shreg_p0   <= '0;
      sdo_dly_p1 <= 1'b0;
    end else if (!en) begin
      cnt        <= '0;
      sck_r      <= 1'b0;
      ws_r       <= 1'b1;
      bitcnt     <= '0;
      shreg_p0   <= '0;
      sdo_dly_p1 <= 1'b0;
    end else begin
      if (tick) begin
        cnt   <= sck_prescaler;
        sck_r <= ~sck_r;
      end else begin
        cnt   <= cnt - 8'd1;
      end
      if (fall) begin
        bitcnt     <= bitcnt + 5'd1;
        // stage p1: I2S output lags the shift register by one SCK
        sdo_dly_p1 <= shreg_p0[31];
        if (bitcnt == 5'd0) begin
          ws_r     <= ~ws_r;
          shreg_p0 <= load_val;
        end else begin
          shreg_p0 <= {shreg_p0[30:0], 1'b0};
        end
      end
    end
  end

  // Sticky underrun flag; clear wins over a simultaneous set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               urun_r <= 1'b0;
    else if (underrun_clr) urun_r <= 1'b0;
    else if (urun_set)     urun_r <= 1'b1;
  end

  assign fifo_full        = full_r;
  assign fifo_empty       = empty_r;
  assign fifo_level       = level;
  assign fifo_level_below = (level < fifo_level_threshold);
  assign underrun         = urun_r;
  assign sck              = sck_r;
  assign ws               = ws_r;
  assign sdo              = left_justified ? shreg_p0[31] : sdo_dly_p1;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx. A receiver model captures (ws, sdo) on
// every SCK rising edge and decodes slots for comparison with pushed words.
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  sck_prescaler;
  logic        left_justified;
  logic [5:0]  sample_size;
  logic [1:0]  channels;
  logic        fifo_wr;
  logic [31:0] fifo_wdata;
  logic        fifo_clr;
  logic [4:0]  fifo_level_threshold;
  logic        underrun_clr;
  logic        fifo_full, fifo_empty, fifo_level_below, underrun;
  logic [4:0]  fifo_level;
  logic        sck, ws, sdo;

  int n_tests = 0;
  int n_fail  = 0;

  bit   cap_en = 1'b0;
  logic sck_prev;
  bit   ws_q[$];
  bit   sd_q[$];

  i2s_tx #(.DW(32), .AW(4)) dut (
    .clk(clk), .rst(rst), .en(en), .sck_prescaler(sck_prescaler),
    .left_justified(left_justified), .sample_size(sample_size), .channels(channels),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .fifo_clr(fifo_clr),
    .fifo_level_threshold(fifo_level_threshold), .underrun_clr(underrun_clr),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .fifo_level_below(fifo_level_below), .underrun(underrun),
    .sck(sck), .ws(ws), .sdo(sdo)
  );

  always #5 clk = ~clk;

  // Receiver model: sample on SCK rising edges.
  always @(negedge clk) begin
    if (cap_en && sck === 1'b1 && sck_prev === 1'b0) begin
      ws_q.push_back(ws);
      sd_q.push_back(sdo);
    end
    sck_prev = sck;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    fifo_wr    = 1'b1;
    fifo_wdata = v;
    step(1);
    fifo_wr    = 1'b0;
  endtask

  task automatic do_reset();
    en = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic cap_start();
    ws_q.delete();
    sd_q.delete();
    cap_en = 1'b1;
  endtask

  // Slot n word: slots start where captured ws changes (ws idles at 1).
  // I2S data starts one rising edge after the slot start.
  function automatic logic [31:0] slot_word(input int n, input bit lj);
    int   starts[$];
    bit   prev;
    int   base;
    logic [31:0] w;
    prev = 1'b1;
    for (int k = 0; k < ws_q.size(); k++) begin
      if (ws_q[k] != prev) starts.push_back(k);
      prev = ws_q[k];
    end
    if (n >= starts.size()) return 'x;
    base = starts[n] + (lj ? 0 : 1);
    w = '0;
    for (int i = 0; i < 32; i++) begin
      if (base + i >= sd_q.size()) return 'x;
      w = {w[30:0], sd_q[base + i]};
    end
    return w;
  endfunction

  function automatic int ones_seen();
    int c;
    c = 0;
    foreach (sd_q[i]) c += int'(sd_q[i]);
    return c;
  endfunction

  function automatic logic [31:0] word_k(input int k);
    return {8'(k + 1), 8'hC3, 8'(8'h5A ^ 8'(k)), 8'(8'h80 | 8'(k))};
  endfunction

  initial begin
    en = 1'b0; sck_prescaler = 8'd1; left_justified = 1'b0; sample_size = 6'd32;
    channels = 2'b11; fifo_wr = 1'b0; fifo_wdata = '0; fifo_clr = 1'b0;
    fifo_level_threshold = 5'd4; underrun_clr = 1'b0;
    rst = 1'b1;
    step(2);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_ws", 32'(ws), 32'd1);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_below", 32'(fifo_level_below), 32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    step(1);

    // FIFO watermark and clear priority over a simultaneous write.
    push(32'h1); push(32'h2); push(32'h3);
    check("lvl3", 32'(fifo_level), 32'd3);
    check("below3", 32'(fifo_level_below), 32'd1);
    push(32'h4);
    check("below4", 32'(fifo_level_below), 32'd0);
    fifo_clr = 1'b1; fifo_wr = 1'b1; fifo_wdata = 32'h5;
    step(1);
    fifo_clr = 1'b0; fifo_wr = 1'b0;
    check("clr_level", 32'(fifo_level), 32'd0);
    check("clr_empty", 32'(fifo_empty), 32'd1);

    // I2S stereo, prescaler 1, 32-bit samples.
    do_reset();
    sck_prescaler = 8'd1; left_justified = 1'b0; sample_size = 6'd32; channels = 2'b11;
    push(32'hA5A50001);
    push(32'h800000FF);
    check("i2s_lvl2", 32'(fifo_level), 32'd2);
    cap_start();
    en = 1'b1;
    step(1);
    check("i2s_sck_rise", 32'(sck), 32'd1);
    check("i2s_ws_before", 32'(ws), 32'd1);
    step(2);
    check("i2s_sck_fall", 32'(sck), 32'd0);
    check("i2s_ws_fall", 32'(ws), 32'd0);
    step(7);
    check("i2s_lvl1", 32'(fifo_level), 32'd1);
    step(130);
    check("i2s_empty", 32'(fifo_empty), 32'd1);
    step(140);
    cap_en = 1'b0;
    check("i2s_left", slot_word(0, 1'b0), 32'hA5A50001);
    check("i2s_right", slot_word(1, 1'b0), 32'h800000FF);
    en = 1'b0;

    // Left-justified, 24-bit sample: MSB on sdo with the ws edge.
    do_reset();
    left_justified = 1'b1; sample_size = 6'd24;
    push(32'h00123456);
    cap_start();
    en = 1'b1;
    step(3);
    check("lj_ws_fall", 32'(ws), 32'd0);
    check("lj_msb", 32'(sdo), 32'd0);
    step(137);
    cap_en = 1'b0;
    check("lj_left", slot_word(0, 1'b1), 32'h12345600);
    en = 1'b0;

    // Enable with an empty FIFO: silent frame, sticky underrun.
    do_reset();
    left_justified = 1'b0; sample_size = 6'd32;
    cap_start();
    en = 1'b1;
    step(2);
    check("ur_before", 32'(underrun), 32'd0);
    step(1);
    check("ur_set", 32'(underrun), 32'd1);
    step(260);
    cap_en = 1'b0;
    check("ur_sdo_ones", 32'(ones_seen()), 32'd0);
    en = 1'b0;
    step(2);
    check("ur_sticky", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    check("ur_clr", 32'(underrun), 32'd0);

    // Fill past full while disabled, then replay all 16 words in order.
    do_reset();
    sck_prescaler = 8'd0;
    for (int k = 0; k < 17; k++) push(word_k(k));
    check("full_flag", 32'(fifo_full), 32'd1);
    check("full_level", 32'(fifo_level), 32'd16);
    check("full_below", 32'(fifo_level_below), 32'd0);
    cap_start();
    en = 1'b1;
    step(1100);
    cap_en = 1'b0;
    for (int k = 0; k < 16; k++) check($sformatf("replay%0d", k), slot_word(k, 1'b0), word_k(k));
    check("replay_drop17", slot_word(16, 1'b0), 32'h0);
    check("replay_underrun", 32'(underrun), 32'd1);

    // Asynchronous reset mid-frame takes effect without a clock edge.
    #2 rst = 1'b1;
    #1;
    check("arst_sck", 32'(sck), 32'd0);
    check("arst_ws", 32'(ws), 32'd1);
    check("arst_sdo", 32'(sdo), 32'd0);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_empty", 32'(fifo_empty), 32'd1);
    check("arst_underrun", 32'(underrun), 32'd0);
    en = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);

    // Mono left: one pop per frame; right slot zeros or duplicate.
    sck_prescaler = 8'd0; channels = 2'b10; left_justified = 1'b0; sample_size = 6'd32;
    push(32'h7FFF0000);
    push(32'h7FFF0000);
    cap_start();
    en = 1'b1;
    step(10);
    check("mono_lvl_f1", 32'(fifo_level), 32'd1);
    step(110);
    check("mono_lvl_mid", 32'(fifo_level), 32'd1);
    step(20);
    check("mono_lvl_f2", 32'(fifo_level), 32'd0);
    cap_en = 1'b0;
    check("mono_left", slot_word(0, 1'b0), 32'h7FFF0000);
`ifdef I2S_TX_MONO_DUP_EN
    check("mono_right", slot_word(1, 1'b0), 32'h7FFF0000);
`else
    check("mono_right", slot_word(1, 1'b0), 32'h0);
`endif
    en = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
